// File: rtl/fifo_avalon_reader_pkg.sv
// Shared register map, bit positions and settle-FSM encoding for the Avalon FIFO reader.
package fifo_avalon_reader_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_POPCNT = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT     = 0;
  localparam int unsigned STATUS_FULL_BIT      = 1;
  localparam int unsigned STATUS_UNDERFLOW_BIT = 2;
  localparam int unsigned STATUS_READY_BIT     = 3;

  localparam int unsigned CTRL_IRQ_EN_BIT = 0;
  localparam int unsigned CTRL_CLR_UF_BIT = 1;

  localparam int unsigned DATA_VALID_BIT = 31;

  typedef enum logic [1:0] {
    StEmpty  = 2'd0,
    StSettle = 2'd1,
    StReady  = 2'd2
  } settle_state_e;

endpackage

// File: rtl/fifo_avalon_reader_if.sv
// Avalon-MM slave bus plus FIFO pop port and interrupt of the FIFO reader.
interface fifo_avalon_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  avs_chipselect;
  logic [1:0]            avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [31:0]           avs_writedata;
  logic [31:0]           avs_readdata;
  logic                  avs_waitrequest;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  irq;

  // View of the reader block itself.
  modport slave (
    input  avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
    input  fifo_r_data, fifo_empty, fifo_full,
    output avs_readdata, avs_waitrequest, fifo_rd, irq
  );

  // View of the surrounding system (Nios II master and FIFO).
  modport master (
    output avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
    output fifo_r_data, fifo_empty, fifo_full,
    input  avs_readdata, avs_waitrequest, fifo_rd, irq
  );
endinterface

// File: rtl/fifo_avalon_reader.sv
// Avalon-MM slave draining a first-word-fall-through FIFO: DATA/STATUS/CTRL/POPCNT registers,
// empty-exit settle guard, sticky underflow and a level interrupt.
module fifo_avalon_reader
  import fifo_avalon_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  fifo_avalon_reader_if.slave  bus
);

  settle_state_e        state_q, state_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 underflow_q, underflow_d;
  logic                 irq_en_q, irq_en_d;
  logic [CNT_WIDTH-1:0] popcnt_q, popcnt_d;
  logic                 irq_q, irq_d;

  logic        rd_sel, data_rd, head_ok, waitrequest, accept, pop, wr_en;
  logic [31:0] data_word, status_word, ctrl_word, cnt_word;
  logic        unused_wd;

  assign unused_wd = ^bus.avs_writedata[31:2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty:  if (!bus.fifo_empty) state_d = StSettle;
      StSettle: state_d = bus.fifo_empty ? StEmpty : StReady;
      StReady:  if (bus.fifo_empty) state_d = StEmpty;
      default:  state_d = StEmpty;
    endcase
  end

  assign rd_sel      = bus.avs_chipselect & bus.avs_read;
  assign data_rd     = rd_sel & (bus.avs_address == REG_DATA);
  // The head is only trusted while still non-empty: after the last pop the FSM lags a cycle.
  assign head_ok     = (state_q == StReady) & ~bus.fifo_empty;
  assign waitrequest = data_rd & (state_q == StSettle);
  assign accept      = rd_sel & ~waitrequest;
  assign pop         = data_rd & head_ok;
  assign wr_en       = bus.avs_chipselect & bus.avs_write & ~bus.avs_read;

  always_comb begin
    data_word                              = '0;
    data_word[DATA_WIDTH-1:0]              = bus.fifo_r_data;
    data_word[DATA_VALID_BIT]              = 1'b1;
    status_word                            = '0;
    status_word[STATUS_EMPTY_BIT]          = bus.fifo_empty;
    status_word[STATUS_FULL_BIT]           = bus.fifo_full;
    status_word[STATUS_UNDERFLOW_BIT]      = underflow_q;
    status_word[STATUS_READY_BIT]          = (state_q == StReady);
    ctrl_word                              = '0;
    ctrl_word[CTRL_IRQ_EN_BIT]             = irq_en_q;
    cnt_word                               = '0;
    cnt_word[CNT_WIDTH-1:0]                = popcnt_q;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (accept) begin
      unique case (bus.avs_address)
        REG_DATA:   readdata_d = head_ok ? data_word : '0;
        REG_STATUS: readdata_d = status_word;
        REG_CTRL:   readdata_d = ctrl_word;
        REG_POPCNT: readdata_d = cnt_word;
        default:    readdata_d = '0;
      endcase
    end
  end

  always_comb begin
    underflow_d = underflow_q;
    irq_en_d    = irq_en_q;
    popcnt_d    = popcnt_q;
    if (pop) popcnt_d = popcnt_q + CNT_WIDTH'(1);
    if (wr_en && bus.avs_address == REG_CTRL) begin
      irq_en_d = bus.avs_writedata[CTRL_IRQ_EN_BIT];
      if (bus.avs_writedata[CTRL_CLR_UF_BIT]) underflow_d = 1'b0;
    end
    if (wr_en && bus.avs_address == REG_POPCNT) popcnt_d = '0;
    // Set after clear so a simultaneous underflow event wins.
    if (data_rd && accept && !head_ok) underflow_d = 1'b1;
    irq_d = irq_en_q & ~bus.fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      readdata_q  <= '0;
      underflow_q <= 1'b0;
      irq_en_q    <= 1'b0;
      popcnt_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      readdata_q  <= readdata_d;
      underflow_q <= underflow_d;
      irq_en_q    <= irq_en_d;
      popcnt_q    <= popcnt_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.avs_readdata    = readdata_q;
  assign bus.avs_waitrequest = waitrequest;
  assign bus.fifo_rd         = pop;
  assign bus.irq             = irq_q;

endmodule

// File: tb/tb_fifo_avalon_reader.sv
// Scoreboard bench for fifo_avalon_reader: directed scenarios plus random traffic against a
// streak-count reference model and a queue-based FWFT FIFO.
module tb_fifo_avalon_reader;
  import fifo_avalon_reader_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_avalon_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_avalon_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Environment FIFO and reference state.
  logic [7:0]  fifo_q[$];
  logic [31:0] exp_q[$];
  logic        push_req = 1'b0;
  logic [7:0]  push_val = '0;
  logic        pend_pop, pend_push;
  logic [7:0]  pend_val;
  int          run;           // consecutive non-empty cycles seen before this one
  logic        m_uf, m_irq_en, m_irq;
  logic [15:0] m_popcnt;

  initial begin
    bus.fifo_empty  = 1'b1;
    bus.fifo_full   = 1'b0;
    bus.fifo_r_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) fifo_q.delete();
      else begin
        if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (pend_push && fifo_q.size() < Depth) fifo_q.push_back(pend_val);
      end
      bus.fifo_empty  = (fifo_q.size() == 0);
      bus.fifo_full   = (fifo_q.size() >= Depth);
      bus.fifo_r_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Reference model: evaluates the cycle at the falling edge and queues expected read data.
  always @(negedge clk) begin
    logic empty, full, data_rd, exp_wait, ready, exp_pop;
    logic [31:0] exp;
    if (!reset_n) begin
      run = 0; m_uf = 0; m_irq_en = 0; m_irq = 0; m_popcnt = 0;
      pend_pop = 0; pend_push = 0; pend_val = 0;
      exp_q.delete();
    end else begin
      empty    = (fifo_q.size() == 0);
      full     = (fifo_q.size() >= Depth);
      data_rd  = bus.avs_chipselect && bus.avs_read && bus.avs_address == REG_DATA;
      ready    = (run >= 2);
      exp_wait = data_rd && run == 1;
      exp_pop  = data_rd && ready && !empty;
      chk("waitrequest", {31'b0, bus.avs_waitrequest}, {31'b0, exp_wait});
      chk("fifo_rd", {31'b0, bus.fifo_rd}, {31'b0, exp_pop});
      chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
      if (bus.avs_chipselect && bus.avs_read && !exp_wait) begin
        case (bus.avs_address)
          2'd0:    exp = exp_pop ? (32'h8000_0000 | {24'b0, fifo_q[0]}) : 32'h0;
          2'd1:    exp = {28'b0, ready, m_uf, full, empty};
          2'd2:    exp = {31'b0, m_irq_en};
          default: exp = {16'b0, m_popcnt};
        endcase
        exp_q.push_back(exp);
        if (data_rd && !exp_pop) m_uf = 1;
      end
      if (exp_pop) m_popcnt = m_popcnt + 16'd1;
      m_irq = m_irq_en && !empty;
      if (bus.avs_chipselect && bus.avs_write && !bus.avs_read) begin
        if (bus.avs_address == REG_CTRL) begin
          m_irq_en = bus.avs_writedata[0];
          if (bus.avs_writedata[1]) m_uf = 0;
        end
        if (bus.avs_address == REG_POPCNT) m_popcnt = 0;
      end
      run       = empty ? 0 : ((run < 2) ? run + 1 : 2);
      pend_pop  = bus.fifo_rd;
      pend_push = push_req;
      pend_val  = push_val;
    end
  end

  // Monitor: one cycle after each accepted read, compare readdata with the queued expectation.
  logic prev_acc = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_acc = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_acc) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL readdata: got 0x%08h expected none queued", bus.avs_readdata);
        end else chk("readdata", bus.avs_readdata, exp_q.pop_front());
      end
      prev_acc = bus.avs_chipselect && bus.avs_read && !bus.avs_waitrequest;
    end
  end

  task automatic set_bus(input logic cs, input logic rd, input logic wr, input logic [1:0] a,
                         input logic [31:0] wd);
    bus.avs_chipselect = cs;
    bus.avs_read       = rd;
    bus.avs_write      = wr;
    bus.avs_address    = a;
    bus.avs_writedata  = wd;
  endtask

  task automatic cycle(input logic push = 1'b0, input logic [7:0] v = 8'h00);
    push_req = push;
    push_val = v;
    @(posedge clk);
    #1;
    push_req = 1'b0;
  endtask

  task automatic idle(input int n);
    set_bus(0, 0, 0, 2'd0, 32'h0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_read(input logic [1:0] a, output int waits);
    logic w;
    waits = 0;
    set_bus(1, 1, 0, a, 32'h0);
    forever begin
      @(negedge clk);
      w = bus.avs_waitrequest;
      @(posedge clk);
      #1;
      if (!w) break;
      waits++;
      if (waits > 8) begin
        errors++; checks++;
        $display("FAIL read_wait: got %0d wait cycles expected at most 8", waits);
        break;
      end
    end
    set_bus(0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
    set_bus(1, 0, 1, a, wd);
    cycle();
    set_bus(0, 0, 0, 2'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    set_bus(0, 0, 0, 2'd0, 32'h0);
    // 1: reset for 3 cycles, FIFO empty.
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_readdata", bus.avs_readdata, 32'h0);
    chk("rst_waitrequest", {31'b0, bus.avs_waitrequest}, 32'h0);
    chk("rst_fifo_rd", {31'b0, bus.fifo_rd}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    idle(1);
    do_read(REG_STATUS, w);
    // Reads without chipselect leave readdata alone.
    set_bus(0, 1, 0, REG_POPCNT, 32'h0);
    cycle();
    chk("cs_low_hold", bus.avs_readdata, 32'h1);

    // 2: underflow on empty read, then clear through CTRL.
    do_read(REG_DATA, w);
    do_read(REG_STATUS, w);
    do_write(REG_CTRL, 32'h2);
    do_read(REG_STATUS, w);

    // 3: single word, read issued once the reader leaves EMPTY.
    set_bus(0, 0, 0, 2'd0, 32'h0);
    cycle(1'b1, 8'hA5);
    idle(1);
    do_read(REG_DATA, w);
    chk("settle_waits", w, 1);
    do_read(REG_POPCNT, w);

    // 4: three words drained back to back.
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    idle(3);
    for (int i = 0; i < 3; i++) do_read(REG_DATA, w);
    idle(2);
    do_read(REG_STATUS, w);

    // 5: interrupt follows non-empty with one cycle lag.
    do_write(REG_CTRL, 32'h1);
    cycle(1'b1, 8'h7E);
    idle(4);
    do_read(REG_DATA, w);
    idle(3);

    // 6: asynchronous reset in the middle of a drain burst.
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    idle(3);
    do_read(REG_DATA, w);
    set_bus(1, 1, 0, REG_DATA, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_fifo_rd", {31'b0, bus.fifo_rd}, 32'h0);
    chk("arst_irq", {31'b0, bus.irq}, 32'h0);
    chk("arst_readdata", bus.avs_readdata, 32'h0);
    set_bus(0, 0, 0, 2'd0, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    idle(1);
    do_read(REG_POPCNT, w);
    do_read(REG_CTRL, w);
    do_write(REG_CTRL, 32'h1);

    // Random traffic, including reads abandoned during waitrequest and read+write collisions.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] a;
      a = ($urandom_range(0, 1) == 0) ? REG_DATA : 2'($urandom_range(0, 3));
      set_bus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) == 0), a, $urandom);
      cycle(logic'($urandom_range(0, 2) == 0), 8'($urandom));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
